// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging primary and FIFO-buffered secondary results
module wb_arbiter #(
    parameter int W     = 5,
    parameter int D     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p_we,
    input  logic [W-1:0]               p_wa,
    input  logic [D-1:0]               p_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [W-1:0]               s_wa,
    input  logic [D-1:0]               s_data,
    input  logic [W-1:0]               ra1,
    input  logic [W-1:0]               ra2,
    output logic                       hazard1,
    output logic                       hazard2,
    output logic                       rf_we,
    output logic [W-1:0]               rf_wa,
    output logic [D-1:0]               rf_data,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Secondary FIFO storage; valid bits let a squashed entry still occupy its slot
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     wa_q   [DEPTH];
    logic [W-1:0]     wa_d   [DEPTH];
    logic [D-1:0]     data_q [DEPTH];
    logic [D-1:0]     data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             rf_we_q, rf_we_d;
    logic [W-1:0]     rf_wa_q, rf_wa_d;
    logic [D-1:0]     rf_data_q, rf_data_d;

    logic             p_req;
    logic             push;
    logic             pop;

    assign s_ready = !rst && (count_q < CW'(DEPTH));
    assign pending = count_q;
    assign rf_we   = rf_we_q;
    assign rf_wa   = rf_wa_q;
    assign rf_data = rf_data_q;

    // Arbitration: primary wins, otherwise drain the FIFO head; squash older matching entries
    always_comb begin
        valid_d   = valid_q;
        wa_d      = wa_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_data_d = rf_data_q;

        p_req = p_we && (p_wa != '0);
        push  = s_valid && s_ready && (s_wa != '0);
        pop   = !p_req && (count_q != '0);

        if (p_req) begin
            rf_we_d   = 1'b1;
            rf_wa_d   = p_wa;
            rf_data_d = p_data;
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (wa_q[i] == p_wa)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            rf_we_d         = valid_q[head_q];
            rf_wa_d         = wa_q[head_q];
            rf_data_d       = data_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        // Push comes after the squash so a same-cycle secondary result survives
        if (push) begin
            valid_d[tail_q] = 1'b1;
            wa_d[tail_q]    = s_wa;
            data_d[tail_q]  = s_data;
            tail_d          = tail_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Hazard detection against the registered write and every live FIFO entry
    always_comb begin
        hazard1 = rf_we_q && (rf_wa_q == ra1);
        hazard2 = rf_we_q && (rf_wa_q == ra2);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (wa_q[i] == ra1)) hazard1 = 1'b1;
            if (valid_q[i] && (wa_q[i] == ra2)) hazard2 = 1'b1;
        end
        if (ra1 == '0) hazard1 = 1'b0;
        if (ra2 == '0) hazard2 = 1'b0;
    end

    // State registers with synchronous reset; reset drops all buffered entries
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_data_q <= rf_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i]   <= wa_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter sitting directly upstream of the register file's single write port (we/wa/data); registered outputs connect one-to-one to that port.
- Merges two result sources into one register-file write per cycle:
  - Primary path: ALU/load results, always accepted, highest priority.
  - Secondary path: multi-cycle mult/div results, valid/ready handshake, buffered in a small FIFO.
- Enforces the r0-is-zero rule and reports pending-write hazards to decode.

Parameters:
W, 5, register address width
D, 32, data width
DEPTH, 2, secondary FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
p_we  in  1  primary write request
p_wa  in  W  primary destination register
p_data  in  D  primary write data
s_valid  in  1  secondary result valid
s_ready  out  1  secondary FIFO can accept (registered-count based)
s_wa  in  W  secondary destination register
s_data  in  D  secondary write data
ra1  in  W  decode read address 1
ra2  in  W  decode read address 2
hazard1  out  1  ra1 has an uncommitted write pending
hazard2  out  1  ra2 has an uncommitted write pending
rf_we  out  1  register file write enable (registered)
rf_wa  out  W  register file write address (registered)
rf_data  out  D  register file write data (registered)
pending  out  clog2(DEPTH)+1  FIFO occupancy, valid and squashed entries both counted

Behaviour:
- Reset (rst=1 at posedge): rf_we=0, rf_wa=0, rf_data=0, FIFO empty, pending=0, all entry valid bits 0.
- s_ready = !rst && (pending < DEPTH). It is computed from the registered count only, so a pop in the same cycle does not free a slot early.
- Primary request: p_req = p_we && (p_wa != 0). When p_we=1 with p_wa=0, the write is discarded and is not a request.
- Secondary push: occurs on s_valid && s_ready.
  - s_wa=0: handshake completes, nothing enqueued, pending unchanged.
  - Otherwise: entry {valid=1, wa, data} is written at the tail.
- Arbitration each cycle, registered into rf_* at the next posedge (1-cycle latency):
  - p_req: rf_we=1, rf_wa=p_wa, rf_data=p_data. FIFO not popped.
  - Else if pending>0: pop head. rf_we=head.valid, rf_wa/rf_data=head fields. A squashed head pops with rf_we=0.
  - Else: rf_we=0. rf_wa/rf_data hold their previous values.
- Ordering squash: when p_req, every valid FIFO entry with wa==p_wa gets valid=0 that cycle. An older secondary result can never overwrite a newer primary result.
- A secondary push in the same cycle as a matching p_req is NOT squashed; the secondary result is newer.
- Simultaneous push and pop: both occur; pending unchanged. Head/tail pointers wrap modulo DEPTH.
- Starvation: the FIFO drains only on cycles without p_req. Upstream guarantees primary bubbles; no internal starvation guard.
- Hazards (combinational), for x in {1,2}: hazardx = (rax != 0) && ((rf_we && rf_wa==rax) || any valid FIFO entry with wa==rax). ra=0 never hazards.
- rst asserted mid-operation: all buffered entries are lost, rf_we=0 next cycle, s_ready=0 while rst=1.

Test Plan:
- Reset then p_we=1, p_wa=3, p_data=0xA5A5 -> next cycle rf_we=1, rf_wa=3, rf_data=0xA5A5; following cycle rf_we=0.
- p_we=1, p_wa=0, p_data=0xFFFF -> rf_we stays 0. Push s_wa=0 -> s_ready handshake ok, pending stays 0.
- Push s_wa=4/0x11, then s_wa=5/0x22 while p_we=1 on other regs for 2 cycles:
  - pending=2, s_ready=0, third s_valid held off.
  - After primary idles: rf writes 4=0x11 then 5=0x22 on consecutive cycles; pending returns to 0.
- Push s_wa=7/0x1, then p_we=1, p_wa=7, p_data=0x2 -> rf writes 7=0x2. The popped entry yields rf_we=0, so reg 7 ends as 0x2.
- With FIFO holding wa=9, ra1=9, ra2=0 -> hazard1=1, hazard2=0. After commit cycle completes, hazard1=0.
- FIFO full, assert rst for one cycle -> pending=0, rf_we=0, s_ready=1 the cycle after rst drops; no stale writes issue.
